maxpool1d_window_sequencer: RTL and testbench
=============================================

Name: maxpool1d_window_sequencer

Overview:
Streaming controller for 1D max pooling over one channel. It latches a per-run configuration (length, kernel, stride) and accepts samples through a valid/ready stream into a circular window buffer. When a window completes, it stalls input, reduces the window to its maximum with one compare per cycle, and emits that maximum on a valid/ready output stream. It sits between the activation streamer and the pooled-output writer and replaces the pass-through pooling stage.

Parameters:
DATA_W, 32, sample width; signed two's complement
MAX_K, 16, maximum kernel size and window buffer depth
LEN_W, 16, width of sequence length and index counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse; latch cfg_* and begin a run (ignored while busy=1)
cfg_len  in  LEN_W  input sequence length L
cfg_kernel  in  $clog2(MAX_K)+1  kernel size K
cfg_stride  in  $clog2(MAX_K)+1  stride S
busy  out  1  high from accepted start until done
done  out  1  single-cycle pulse after the last input is consumed
cfg_err  out  1  single-cycle pulse when start carries an illegal config
in_valid  in  1  input sample valid
in_ready  out  1  block accepts a sample
in_data  in  DATA_W  input sample
out_valid  out  1  pooled result valid
out_ready  in  1  downstream accepts the result
out_data  out  DATA_W  pooled maximum
out_last  out  1  qualifies the final result of a run

Behaviour:
- Reset (sync, rst=1): state IDLE. busy, done, cfg_err, in_ready, out_valid and out_last are 0. out_data is 0. All counters and pointers are 0. Buffer contents are don't-care. Reset mid-run aborts the run immediately, with no done.
- Legal config: 1<=K<=MAX_K, 1<=S, K<=L. Otherwise, start in IDLE produces a cfg_err pulse the next cycle and the block stays IDLE with busy=0.
- Number of outputs N = floor((L-K)/S)+1. Window n covers sample indices n*S .. n*S+K-1.
- States:
  - IDLE: on legal start, latch config, set idx=0 and next_end=K-1, then go to FILL.
  - FILL: in_ready=1. On each handshake, write in_data to buf[wp], increment wp mod MAX_K and idx. If the accepted index equals next_end, go to REDUCE. If idx reaches L with no window pending, go to DONE.
  - REDUCE: in_ready=0. Start at rp=(wp-K) mod MAX_K. Cycle 0 loads acc=buf[rp]; each following cycle does acc=max(acc,buf[rp+j]) as a signed compare. This takes exactly K cycles, then go to EMIT.
  - EMIT: out_valid=1 and out_data=acc. out_last=1 iff this is window N-1. out_data and out_last stay stable until out_ready. On handshake, next_end+=S.
    - If this was the last window and idx<L, go to FILL to drain the trailing samples (no further outputs).
    - If this was the last window and idx==L, go to DONE.
    - Otherwise go to FILL.
  - DONE: done=1 for one cycle, busy drops the same cycle, go to IDLE.
- Latency: the last sample of a window is accepted at cycle t, the reduce runs t+1..t+K, and out_valid asserts at t+K+1.
- S>K: gap samples are accepted and written to the buffer but never reduced. S<K: overlapping samples are re-read from the buffer, so the buffer must hold the last K samples (MAX_K>=K).
- in_ready is never asserted outside FILL. The block does not accept an output and an input in the same cycle.
- in_valid while IDLE is ignored. out_ready while out_valid=0 is ignored.
- Index counters use LEN_W bits, and next_end comparisons are done at LEN_W+1 bits to avoid wrap.

Decomposition:
- Shared package maxpool_pkg: state enum (IDLE, FILL, REDUCE, EMIT, DONE), DATA_W/MAX_K/LEN_W defaults, and a signed max function.
- One sub-module, maxpool_window_buf: an MAX_K x DATA_W circular register file with a write port plus a combinational read port, holding the pointer wrap logic.

Test Plan:
1. L=8, K=2, S=2; data 3,-1,7,2,0,0,-5,-9 -> outputs 3,7,0,-5; out_last only on -5; one done pulse; busy=0 afterwards.
2. L=5, K=3, S=1; data 1,5,2,4,3 -> outputs 5,5,4. The first out_valid arrives exactly 4 cycles after the 3rd input handshake.
3. L=7, K=2, S=3; data 1..7 -> outputs 2,5. Samples 6 and 7 are still consumed (7 input handshakes total) before done.
4. Backpressure: in test 1, hold out_ready=0 for 5 cycles at the first result -> out_data=3 stays stable, in_ready=0 throughout, and the final output sequence is unchanged.
5. Config errors: start with K=0, then with S=0, then with K=17, then with L=1,K=2 -> each gives one cfg_err pulse, busy stays 0, and in_ready stays 0.
6. Start ignored and reset mid-run: pulse start again during test 2 -> ignored. Assert rst while in REDUCE -> next cycle all outputs are 0 and the state is IDLE. A fresh run of test 1 then passes.

Source files
------------

// File: rtl/maxpool_pkg.sv
// rtl/maxpool_pkg.sv - shared constants, FSM encodings and signed max for the 1D max-pool sequencer
package maxpool_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_MAX_K  = 16;
    localparam int DEF_LEN_W  = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FILL   = 3'd1;
    localparam logic [2:0] ST_REDUCE = 3'd2;
    localparam logic [2:0] ST_EMIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Two's complement maximum; ties keep the first operand.
    function automatic logic [DEF_DATA_W-1:0] smax(
        input logic [DEF_DATA_W-1:0] a,
        input logic [DEF_DATA_W-1:0] b
    );
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_window_buf.sv
// rtl/maxpool_window_buf.sv - circular MAX_K-deep sample buffer, read addressed relative to the write pointer
module maxpool_window_buf #(
    parameter int  DATA_W = 32,
    parameter int  MAX_K  = 16,
    localparam int AW     = (MAX_K > 1) ? $clog2(MAX_K) : 1,
    localparam int BW     = $clog2(MAX_K) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BW-1:0]     rd_back,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [MAX_K];
    logic [AW-1:0]     wp_q;
    logic [AW-1:0]     wp_d;
    logic [BW-1:0]     wp_ext;
    logic [AW-1:0]     rd_addr;

    always_comb begin
        wp_d = wp_q;
        if (clr) begin
            wp_d = '0;
        end else if (wr_en) begin
            wp_d = (wp_q == AW'(MAX_K - 1)) ? '0 : wp_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
        end else begin
            wp_q <= wp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    // rd_back=1 addresses the most recent write; explicit wrap keeps non power-of-two depths correct.
    assign wp_ext  = {{(BW-AW){1'b0}}, wp_q};
    assign rd_addr = (wp_ext >= rd_back) ? AW'(wp_ext - rd_back)
                                         : AW'(wp_ext + BW'(MAX_K) - rd_back);
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/maxpool1d_window_sequencer.sv
// rtl/maxpool1d_window_sequencer.sv - streaming 1D max-pool controller: fill window, serial reduce, emit
module maxpool1d_window_sequencer
    import maxpool_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  MAX_K  = DEF_MAX_K,
    parameter int  LEN_W  = DEF_LEN_W,
    localparam int KW     = $clog2(MAX_K) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [KW-1:0]     cfg_kernel,
    input  logic [KW-1:0]     cfg_stride,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    logic [2:0]        state_q,    state_d;
    logic [LEN_W-1:0]  len_q,      len_d;
    logic [KW-1:0]     k_q,        k_d;
    logic [KW-1:0]     s_q,        s_d;
    logic [LEN_W-1:0]  idx_q,      idx_d;
    logic [LEN_W:0]    next_end_q, next_end_d;
    logic [KW-1:0]     cnt_q,      cnt_d;
    logic [DATA_W-1:0] acc_q,      acc_d;
    logic              cfg_err_q,  cfg_err_d;

    logic              buf_clr;
    logic              buf_wr;
    logic [KW-1:0]     rd_back;
    logic [DATA_W-1:0] rd_data;

    logic              cfg_legal;
    logic [LEN_W:0]    idx_ext;
    logic [LEN_W:0]    len_ext;
    logic [LEN_W:0]    s_ext;
    logic              window_hit;
    logic              input_end;
    logic              last_window;

    assign cfg_legal = (cfg_kernel != '0)
                    && (cfg_kernel <= KW'(MAX_K))
                    && (cfg_stride != '0)
                    && ({{(LEN_W-KW){1'b0}}, cfg_kernel} <= cfg_len);

    // Index arithmetic carries one extra bit so next_end can run past L without wrapping.
    assign idx_ext     = {1'b0, idx_q};
    assign len_ext     = {1'b0, len_q};
    assign s_ext       = {{(LEN_W+1-KW){1'b0}}, s_q};
    assign window_hit  = (idx_ext == next_end_q);
    assign input_end   = ((idx_ext + (LEN_W+1)'(1)) == len_ext);
    assign last_window = ((next_end_q + s_ext) >= len_ext);

    // Cycle j of the reduce reads the window's j-th oldest sample.
    assign rd_back = k_q - cnt_q;

    maxpool_window_buf #(
        .DATA_W (DATA_W),
        .MAX_K  (MAX_K)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (in_data),
        .rd_back (rd_back),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        k_d        = k_q;
        s_d        = s_q;
        idx_d      = idx_q;
        next_end_d = next_end_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        cfg_err_d  = 1'b0;
        buf_clr    = 1'b0;
        buf_wr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_legal) begin
                        len_d      = cfg_len;
                        k_d        = cfg_kernel;
                        s_d        = cfg_stride;
                        idx_d      = '0;
                        cnt_d      = '0;
                        next_end_d = {{(LEN_W+1-KW){1'b0}}, cfg_kernel} - (LEN_W+1)'(1);
                        buf_clr    = 1'b1;
                        state_d    = ST_FILL;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            ST_FILL: begin
                if (in_valid) begin
                    buf_wr = 1'b1;
                    idx_d  = idx_q + LEN_W'(1);
                    if (window_hit) begin
                        cnt_d   = '0;
                        state_d = ST_REDUCE;
                    end else if (input_end) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_REDUCE: begin
                acc_d = (cnt_q == '0) ? rd_data : smax(acc_q, rd_data);
                if (cnt_q == k_q - KW'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + KW'(1);
                end
            end

            ST_EMIT: begin
                if (out_ready) begin
                    next_end_d = next_end_q + s_ext;
                    if (last_window && (idx_q == len_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            k_q        <= '0;
            s_q        <= '0;
            idx_q      <= '0;
            next_end_q <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            k_q        <= k_d;
            s_q        <= s_d;
            idx_q      <= idx_d;
            next_end_q <= next_end_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign busy      = (state_q == ST_FILL) || (state_q == ST_REDUCE) || (state_q == ST_EMIT);
    assign done      = (state_q == ST_DONE);
    assign cfg_err   = cfg_err_q;
    assign in_ready  = (state_q == ST_FILL);
    assign out_valid = (state_q == ST_EMIT);
    assign out_data  = acc_q;
    assign out_last  = out_valid && last_window;

endmodule

// File: tb/tb_maxpool1d_window_sequencer.sv
// tb/tb_maxpool1d_window_sequencer.sv - directed scoreboard bench for the 1D max-pool sequencer
module tb_maxpool1d_window_sequencer;

    localparam int DATA_W = 32;
    localparam int MAX_K  = 16;
    localparam int LEN_W  = 16;
    localparam int KW     = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic [KW-1:0]     cfg_kernel;
    logic [KW-1:0]     cfg_stride;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    always #5 clk = ~clk;

    maxpool1d_window_sequencer #(
        .DATA_W (DATA_W),
        .MAX_K  (MAX_K),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_len    (cfg_len),
        .cfg_kernel (cfg_kernel),
        .cfg_stride (cfg_stride),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    int                errors = 0;
    int                checks = 0;
    int                stim_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_last_q[$];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Reference pooling of stim_q into the scoreboard.
    task automatic build_expect(input int l, input int k, input int s);
        int n;
        n = (l - k) / s + 1;
        exp_q.delete();
        exp_last_q.delete();
        for (int w = 0; w < n; w++) begin
            int m;
            m = stim_q[w*s];
            for (int j = 1; j < k; j++) begin
                if (stim_q[w*s+j] > m) m = stim_q[w*s+j];
            end
            exp_q.push_back(m);
            exp_last_q.push_back(w == n - 1);
        end
    endtask

    task automatic pulse_start(input int l, input int k, input int s);
        @(negedge clk);
        cfg_len    = LEN_W'(l);
        cfg_kernel = KW'(k);
        cfg_stride = KW'(s);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " busy"},      32'(busy),      32'd0);
        check({name, " done"},      32'(done),      32'd0);
        check({name, " cfg_err"},   32'(cfg_err),   32'd0);
        check({name, " in_ready"},  32'(in_ready),  32'd0);
        check({name, " out_valid"}, 32'(out_valid), 32'd0);
        check({name, " out_last"},  32'(out_last),  32'd0);
        check({name, " out_data"},  out_data,       32'd0);
    endtask

    task automatic run_case(input string name, input int l, input int k, input int s,
                            input int hold, input bit restart, input int abort_after);
        int n_in = 0, n_out = 0, n_done = 0, cyc = 0, held = 0;
        int hs_k_cyc = -1, first_ov = -1;
        bit fin = 1'b0;
        logic [DATA_W-1:0] want;
        logic              want_last;

        build_expect(l, k, s);
        pulse_start(l, k, s);
        check({name, " busy after start"}, 32'(busy), 32'd1);

        while (!fin) begin
            if (abort_after > 0 && n_in >= abort_after && busy && !in_ready && !out_valid) begin
                rst       = 1'b1;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                check_all_zero({name, " after reset"});
                rst = 1'b0;
                return;
            end

            in_valid = (n_in < l);
            in_data  = (n_in < l) ? stim_q[n_in] : 0;
            if (restart && cyc == 3) begin
                cfg_len = 2; cfg_kernel = 1; cfg_stride = 1; start = 1'b1;
            end else begin
                start = 1'b0;
            end

            if (out_valid && n_out == 0 && held < hold) begin
                out_ready = 1'b0;
                held++;
                check({name, " held out_data"}, out_data, exp_q[0]);
                check({name, " held in_ready"}, 32'(in_ready), 32'd0);
            end else begin
                out_ready = 1'b1;
            end

            if (out_valid && first_ov < 0) first_ov = cyc;
            if (in_valid && in_ready) begin
                n_in++;
                if (n_in == k) hs_k_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                check({name, " no in/out overlap"}, 32'(in_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    check({name, " unexpected output"}, 32'd1, 32'd0);
                end else begin
                    want      = exp_q.pop_front();
                    want_last = exp_last_q.pop_front();
                    check($sformatf("%s out_data[%0d]", name, n_out), out_data, want);
                    check($sformatf("%s out_last[%0d]", name, n_out), 32'(out_last), 32'(want_last));
                end
                n_out++;
            end
            if (done) begin
                n_done++;
                fin = 1'b1;
            end
            cyc++;
            if (cyc > 500) begin
                check({name, " timeout waiting for done"}, 32'(cyc), 32'd500);
                fin = 1'b1;
            end
            @(negedge clk);
        end

        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({name, " input handshakes"}, 32'(n_in), 32'(l));
        check({name, " outputs missing"}, 32'(exp_q.size()), 32'd0);
        check({name, " first result latency"}, 32'(first_ov - hs_k_cyc), 32'(k + 1));
        check({name, " busy after done"}, 32'(busy), 32'd0);
        check({name, " done is one pulse"}, 32'(done), 32'd0);
        check({name, " done count"}, 32'(n_done), 32'd1);
    endtask

    task automatic cfg_err_case(input string name, input int l, input int k, input int s);
        @(negedge clk);
        cfg_len = LEN_W'(l); cfg_kernel = KW'(k); cfg_stride = KW'(s);
        start = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, " cfg_err pulse"}, 32'(cfg_err), 32'd1);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " in_ready"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        check({name, " cfg_err clears"}, 32'(cfg_err), 32'd0);
        check({name, " still idle"}, 32'(busy), 32'd0);
        check({name, " in_ready idle"}, 32'(in_ready), 32'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_kernel = '0; cfg_stride = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        in_valid = 1'b1; in_data = 32'd99;
        repeat (3) @(negedge clk);
        check("idle in_ready", 32'(in_ready), 32'd0);
        check("idle busy", 32'(busy), 32'd0);
        in_valid = 1'b0;

        stim_q = '{3, -1, 7, 2, 0, 0, -5, -9};
        run_case("t1", 8, 2, 2, 0, 1'b0, 0);

        stim_q = '{1, 5, 2, 4, 3};
        run_case("t2", 5, 3, 1, 0, 1'b1, 0);

        stim_q = '{1, 2, 3, 4, 5, 6, 7};
        run_case("t3", 7, 2, 3, 0, 1'b0, 0);

        stim_q = '{3, -1, 7, 2, 0, 0, -5, -9};
        run_case("t4", 8, 2, 2, 5, 1'b0, 0);

        cfg_err_case("t5 K=0",  8, 0, 1);
        cfg_err_case("t5 S=0",  8, 2, 0);
        cfg_err_case("t5 K=17", 32, 17, 1);
        cfg_err_case("t5 K>L",  1, 2, 1);

        stim_q = '{3, -1, 7, 2, 0, 0, -5, -9};
        run_case("t6 abort", 8, 2, 2, 0, 1'b0, 2);
        @(negedge clk);
        check("t6 idle after reset", 32'(busy), 32'd0);
        run_case("t6 fresh", 8, 2, 2, 0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
